// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, qualifies the start bit, samples
// each bit at its centre and strobes out each correctly framed character.
`timescale 1ns/1ps

module uart_rx #(
   parameter int unsigned CLKS_PER_BIT  = 217,
   parameter int unsigned NUM_DATA_BITS = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_rx,
   output logic [NUM_DATA_BITS-1:0] o_rxByte,
   output logic                     o_rxValid,
   output logic                     o_rxActive,
   output logic                     o_errorFlag
);

   localparam int unsigned CNT_W = 16;
   localparam int unsigned BIT_W = $clog2(NUM_DATA_BITS);
   localparam logic [CNT_W-1:0] HALF     = CNT_W'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CNT_W-1:0] FULL     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NUM_DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   logic                     rx_meta_q, rx_s_q;
   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         clk_cnt_q, clk_cnt_d;
   logic [BIT_W-1:0]         bit_idx_q, bit_idx_d;
   logic [NUM_DATA_BITS-1:0] shift_q, shift_d;
   logic [NUM_DATA_BITS-1:0] rx_byte_q, rx_byte_d;
   logic                     rx_valid_q, rx_valid_d;
   logic                     rx_active_q, rx_active_d;
   logic                     error_q, error_d;

   // Two-flop synchroniser; idle-high so reset does not look like a start edge
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= i_rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         rx_byte_q   <= '0;
         rx_valid_q  <= 1'b0;
         rx_active_q <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         rx_byte_q   <= rx_byte_d;
         rx_valid_q  <= rx_valid_d;
         rx_active_q <= rx_active_d;
         error_q     <= error_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      rx_byte_d  = rx_byte_q;
      rx_valid_d = 1'b0;
      error_d    = error_q;

      unique case (state_q)
         S_IDLE: begin
            clk_cnt_d = '0;
            if (!rx_s_q) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (clk_cnt_q == HALF) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? S_IDLE : S_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end

         S_DATA: begin
            if (clk_cnt_q == FULL) begin
               clk_cnt_d = '0;
               // Shift in at the MSB so the first (LSB) bit ends up at bit 0
               shift_d   = {rx_s_q, shift_q[NUM_DATA_BITS-1:1]};
               if (bit_idx_q == LAST_BIT) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end

         S_STOP: begin
            if (clk_cnt_q == FULL) begin
               clk_cnt_d = '0;
               if (rx_s_q) begin
                  rx_byte_d  = shift_q;
                  rx_valid_d = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  error_d = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
         end

         S_BREAK: begin
            clk_cnt_d = '0;
            if (rx_s_q) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      rx_active_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
   end

   assign o_rxByte    = rx_byte_q;
   assign o_rxValid   = rx_valid_q;
   assign o_rxActive  = rx_active_q;
   assign o_errorFlag = error_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a 16-clock/bit instance for framing cases and
// a 217-clock/bit instance for bit-rate tolerance, with a byte scoreboard each.
`timescale 1ns/1ps

module tb_uart_rx;

   localparam int unsigned N1 = 16;
   localparam int unsigned N2 = 217;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       rx1, rx2;
   logic [7:0] byte1, byte2;
   logic       valid1, valid2, active1, active2, err1, err2;

   uart_rx #(.CLKS_PER_BIT(N1), .NUM_DATA_BITS(8)) dut16 (
      .i_clk(clk), .i_reset(rst), .i_rx(rx1),
      .o_rxByte(byte1), .o_rxValid(valid1), .o_rxActive(active1), .o_errorFlag(err1)
   );

   uart_rx #(.CLKS_PER_BIT(N2), .NUM_DATA_BITS(8)) dut217 (
      .i_clk(clk), .i_reset(rst), .i_rx(rx2),
      .o_rxByte(byte2), .o_rxValid(valid2), .o_rxActive(active2), .o_errorFlag(err2)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int valid_cyc1 = 0;
   logic [7:0] q1[$];
   logic [7:0] q2[$];
   logic [7:0] exp1, exp2;
   logic       prev_valid1 = 1'b0, prev_valid2 = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard monitors: every valid strobe must match the oldest expected byte
   always @(negedge clk) begin
      if (!rst && valid1) begin
         valid_cyc1 = cyc;
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL dut16_unexpected_valid: got byte 0x%02h, required no valid", byte1);
         end else begin
            exp1 = q1.pop_front();
            if (byte1 !== exp1) begin
               errors++;
               $display("FAIL dut16_byte: got 0x%02h, required 0x%02h", byte1, exp1);
            end
         end
         checks++;
         if (prev_valid1) begin
            errors++;
            $display("FAIL dut16_valid_width: got valid high 2 cycles, required 1");
         end
      end
      prev_valid1 = valid1;
   end

   always @(negedge clk) begin
      if (!rst && valid2) begin
         checks++;
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL dut217_unexpected_valid: got byte 0x%02h, required no valid", byte2);
         end else begin
            exp2 = q2.pop_front();
            if (byte2 !== exp2) begin
               errors++;
               $display("FAIL dut217_byte: got 0x%02h, required 0x%02h", byte2, exp2);
            end
         end
      end
      prev_valid2 = valid2;
   end

   task automatic send_bit(input bit sel, input logic v, input int n);
      if (sel) rx2 = v;
      else     rx1 = v;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame; good frames are pushed to the scoreboard up front
   task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop,
                             input int n, input bit chk_act);
      if (stop) begin
         if (sel) q2.push_back(d);
         else     q1.push_back(d);
      end
      send_bit(sel, 1'b0, n);
      for (int i = 0; i < 8; i++) begin
         if (chk_act) begin
            send_bit(sel, d[i], n / 2);
            check($sformatf("active_bit%0d", i), 32'(active1), 1);
            repeat (n - n / 2) @(negedge clk);
         end else begin
            send_bit(sel, d[i], n);
         end
      end
      send_bit(sel, stop, n);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         hold;
      logic [7:0] exp_byte;
      logic       exp_err;
   } vec_t;

   vec_t vecs[6];
   int   start_cyc;
   int   lat;

   initial begin
      repeat (100000) @(posedge clk);
      $display("FAIL timeout: got no finish, required finish within 100000 cycles");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{8'h5A, 1'b1, 0,   8'h5A, 1'b0};
      vecs[1] = '{8'h00, 1'b1, 0,   8'h00, 1'b0};
      vecs[2] = '{8'hFF, 1'b1, 0,   8'hFF, 1'b0};
      vecs[3] = '{8'h3C, 1'b1, 0,   8'h3C, 1'b0};
      vecs[4] = '{8'h81, 1'b0, 100, 8'h3C, 1'b1};
      vecs[5] = '{8'h42, 1'b1, 0,   8'h42, 1'b1};

      rst = 1'b1;
      rx1 = 1'b1;
      rx2 = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_byte",   32'(byte1),   0);
      check("reset_valid",  32'(valid1),  0);
      check("reset_active", 32'(active1), 0);
      check("reset_err",    32'(err1),    0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Ideal frame: latency, active window, clean byte
      start_cyc = cyc;
      send_frame(1'b0, 8'hA5, 1'b1, N1, 1'b1);
      lat = valid_cyc1 - start_cyc;
      checks++;
      if (lat < 154 || lat > 156) begin
         errors++;
         $display("FAIL latency: got %0d cycles, required 155+-1", lat);
      end
      repeat (4) @(negedge clk);
      check("a5_byte",      32'(byte1),   32'h A5);
      check("a5_active_lo", 32'(active1), 0);
      check("a5_err",       32'(err1),    0);

      // Start glitch shorter than half a bit must be ignored
      send_bit(1'b0, 1'b0, 5);
      send_bit(1'b0, 1'b1, 30);
      check("glitch_active", 32'(active1), 0);
      check("glitch_err",    32'(err1),    0);
      check("glitch_byte",   32'(byte1),   32'h A5);

      // Back-to-back table, including a framing error held as a break
      for (int i = 0; i < 6; i++) begin
         send_frame(1'b0, vecs[i].data, vecs[i].stop, N1, 1'b0);
         if (vecs[i].hold > 0) begin
            send_bit(1'b0, 1'b0, vecs[i].hold);
            send_bit(1'b0, 1'b1, 4);
         end
         check($sformatf("vec%0d_byte", i), 32'(byte1), 32'(vecs[i].exp_byte));
         check($sformatf("vec%0d_err", i),  32'(err1),  32'(vecs[i].exp_err));
      end
      repeat (20) @(negedge clk);
      check("err_sticky", 32'(err1), 1);

      // Reset in the middle of data bit 3 of 0xC3
      send_bit(1'b0, 1'b0, N1);
      send_bit(1'b0, 1'b1, N1);
      send_bit(1'b0, 1'b1, N1);
      send_bit(1'b0, 1'b0, N1);
      send_bit(1'b0, 1'b0, N1 / 2);
      check("pre_reset_active", 32'(active1), 1);
      #3 rst = 1'b1;
      #1;
      check("midrst_byte",   32'(byte1),   0);
      check("midrst_valid",  32'(valid1),  0);
      check("midrst_active", 32'(active1), 0);
      check("midrst_err",    32'(err1),    0);
      rx1 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      send_frame(1'b0, 8'h7E, 1'b1, N1, 1'b0);
      repeat (4) @(negedge clk);
      check("post_rst_byte", 32'(byte1), 32'h 7E);
      check("post_rst_err",  32'(err1),  0);

      // Bit-period tolerance at roughly -3% and +3%
      send_frame(1'b1, 8'h55, 1'b1, 210, 1'b0);
      send_frame(1'b1, 8'h55, 1'b1, 224, 1'b0);
      repeat (20) @(negedge clk);
      check("tol_byte",   32'(byte2),   32'h 55);
      check("tol_err",    32'(err2),    0);
      check("tol_active", 32'(active2), 0);

      repeat (50) @(negedge clk);
      check("q16_drained",  q1.size(), 0);
      check("q217_drained", q2.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
